imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface driven by the program counter.
- Accepts one word-aligned fetch address per request over a valid/ready handshake.
- Returns the 32-bit instruction after a fixed number of wait states, flagging misaligned or out-of-range fetches.
- Includes a program-load write port, used by benches and boot, to fill the instruction store.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words (power of two, 16..65536).
- WAIT_CYCLES, 1, extra wait states per valid fetch (0..15).
- NOP_INSTR, 32'h00000013, word returned on an errored fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address of the fetch (PC value).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_instr  out  32  fetched instruction word.
- resp_err  out  1  fetch error: misaligned or out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  program-load byte address.
- prog_wdata  in  32  program-load data word.
- busy  out  1  request in flight (state != IDLE).

Behaviour:
- Clock and reset: clk, with reset synchronous, active-high.
- Reset: state=IDLE, wait counter=0, resp_valid=0, resp_instr=0, resp_err=0. Memory contents are not cleared.
- req_ready = (state==IDLE), decoded from registered state only. busy = !req_ready.
- Word index = req_addr[31:2]. misaligned = req_addr[1:0]!=0. out_of_range = req_addr[31:2] >= DEPTH. err = misaligned | out_of_range.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, handshake (req_valid & req_ready):
    - Latch the address.
    - If err, or WAIT_CYCLES==0: go to RESP.
    - Otherwise: go to WAIT with counter=WAIT_CYCLES.
  - WAIT: decrement the counter each cycle. When counter==1, go to RESP.
  - RESP: hold resp_valid=1, with resp_instr and resp_err stable, until resp_ready=1. On that edge go to IDLE; resp_valid=0 the next cycle.
- Response data:
  - resp_instr and resp_err are registered on the edge entering RESP.
  - Valid fetch: resp_instr = mem[index], resp_err=0.
  - Errored fetch: resp_instr = NOP_INSTR, resp_err=1.
- Latency, measured from the accepting edge to resp_valid high:
  - Valid fetch: 1+WAIT_CYCLES cycles.
  - Errored fetch: 1 cycle.
- Throughput: no overlap, because req_ready=0 during WAIT and RESP. Minimum period per valid fetch is 2+WAIT_CYCLES cycles when resp_ready is held high.
- resp_instr and resp_err keep their last value after the handshake; they are meaningful only while resp_valid=1.
- Program load:
  - prog_we=1 with prog_addr[31:2] < DEPTH writes mem[prog_addr[31:2]] at the edge, in any state.
  - prog_addr[1:0] is ignored. Out-of-range writes are dropped silently.
- Simultaneous write and capture: if a write hits the same word on the edge entering RESP, the response carries the OLD word (read-before-write). A write during WAIT to the in-flight word is visible in the response.
- Reset mid-operation (WAIT or RESP): the pending fetch is abandoned with no response. Next cycle: IDLE, resp_valid=0, req_ready=1.
- Handshake protocol: req_addr is sampled only on the accepting edge and may change afterwards. resp_ready is ignored outside RESP.

Test Plan:
- Preload mem[0..3] = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. WAIT_CYCLES=1, resp_ready=1. Request addr 0x0, then 0x4 -> 0x00500093 two cycles after the first accept; 0x00A00113 two cycles after the second accept; resp_err=0; req_ready low during WAIT and RESP.
- Request addr 0x6 -> resp_valid one cycle after accept, resp_instr=0x00000013, resp_err=1, no wait states.
- DEPTH=1024, request addr 0x00001000 (index 1024) -> resp_err=1, resp_instr=0x00000013. Write prog_addr=0x00001000 -> no memory change; re-fetching index 0 returns its old value.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1 and resp_instr stays stable. req_valid held high is not accepted until one cycle after resp_ready rises.
- With WAIT_CYCLES=3, assert reset during WAIT -> next cycle resp_valid=0, req_ready=1, busy=0. Memory still returns the preloaded data afterwards.
- WAIT_CYCLES=0: prog_we to word 2 with 0xDEADBEEF on the same edge that accepts a fetch of 0x8 -> response 0x002081B3 (old word); an immediate re-fetch returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch port: valid/ready request in,
// registered instruction response out after WAIT_CYCLES wait states.
module imem_fetch_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     resp_instr_q;
  logic            resp_err_q;

  logic            req_fire;
  logic            req_mis, req_oor, req_err;
  logic [AW-1:0]   req_idx;
  logic            prog_hit;
  logic [AW-1:0]   prog_idx;
  logic            capture;
  logic            cap_err;
  logic [AW-1:0]   cap_idx;
  logic            unused_prog;

  assign req_ready  = (state == IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (state == RESP);
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;

  assign unused_prog = &{1'b0, prog_addr[1:0]};

  always_comb begin
    req_fire = req_valid & req_ready;
    req_mis  = (req_addr[1:0] != 2'b00);
    req_oor  = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    req_err  = req_mis | req_oor;
    req_idx  = req_addr[AW+1:2];
    prog_hit = prog_we & ({2'b00, prog_addr[31:2]} < 32'(DEPTH));
    prog_idx = prog_addr[AW+1:2];
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    cap_err  = 1'b0;
    cap_idx  = idx_q;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_err || (WAIT_CYCLES == 0)) begin
            state_nx = RESP;
            capture  = 1'b1;
            cap_err  = req_err;
            cap_idx  = req_idx;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        // WAIT is only entered for error-free fetches, so cap_err stays 0.
        if (cnt == 4'd1) begin
          state_nx = RESP;
          capture  = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (req_fire) begin
        idx_q <= req_idx;
        cnt   <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // Reads the array before this edge's program write lands.
      if (capture) begin
        resp_instr_q <= cap_err ? NOP_INSTR : mem[cap_idx];
        resp_err_q   <= cap_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_hit) mem[prog_idx] <= prog_wdata;
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: three instances with
// WAIT_CYCLES = 1, 3 and 0, each driven by its own stimulus set.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_instr [3];
  logic        resp_err   [3];
  logic        prog_we    [3];
  logic [31:0] prog_addr  [3];
  logic [31:0] prog_wdata [3];
  logic        busy       [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH(1024),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : 0),
      .NOP_INSTR(32'h00000013)
    ) dut (
      .clk(clk),
      .reset(reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr(req_addr[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_instr(resp_instr[g]),
      .resp_err(resp_err[g]),
      .prog_we(prog_we[g]),
      .prog_addr(prog_addr[g]),
      .prog_wdata(prog_wdata[g]),
      .busy(busy[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int i, input logic [31:0] a, input logic [31:0] d);
    prog_we[i] = 1'b1; prog_addr[i] = a; prog_wdata[i] = d;
    step();
    prog_we[i] = 1'b0; prog_addr[i] = '0; prog_wdata[i] = '0;
  endtask

  task automatic preload(input int i);
    prog(i, 32'h0, 32'h00500093);
    prog(i, 32'h4, 32'h00A00113);
    prog(i, 32'h8, 32'h002081B3);
    prog(i, 32'hC, 32'h00000013);
  endtask

  task automatic fetch(input int i, input logic [31:0] a, input logic [31:0] e_instr,
                       input logic e_err, input int e_lat, input string nm);
    int lat;
    chk($sformatf("%s idle ready", nm), 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1; req_addr[i] = a; resp_ready[i] = 1'b1;
    step();
    req_valid[i] = 1'b0; req_addr[i] = $urandom;
    lat = 1;
    while (!resp_valid[i] && lat < 20) begin
      chk($sformatf("%s wait ready", nm), 32'(req_ready[i]), 32'd0);
      step();
      lat++;
    end
    chk($sformatf("%s latency", nm), 32'(lat), 32'(e_lat));
    chk($sformatf("%s instr", nm), resp_instr[i], e_instr);
    chk($sformatf("%s err", nm), 32'(resp_err[i]), 32'(e_err));
    chk($sformatf("%s resp busy", nm), 32'(busy[i]), 32'd1);
    step();
    chk($sformatf("%s done valid", nm), 32'(resp_valid[i]), 32'd0);
    chk($sformatf("%s done ready", nm), 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] held;

    vt[0] = '{32'h0000_0000, 32'h00500093, 1'b0, 2};
    vt[1] = '{32'h0000_0004, 32'h00A00113, 1'b0, 2};
    vt[2] = '{32'h0000_0008, 32'h002081B3, 1'b0, 2};
    vt[3] = '{32'h0000_000C, 32'h00000013, 1'b0, 2};
    vt[4] = '{32'h0000_0006, 32'h00000013, 1'b1, 1};
    vt[5] = '{32'h0000_0001, 32'h00000013, 1'b1, 1};
    vt[6] = '{32'h0000_1000, 32'h00000013, 1'b1, 1};
    vt[7] = '{32'h0000_0FFC, 32'h12345678, 1'b0, 2};
    vt[8] = '{32'hFFFF_FFFC, 32'h00000013, 1'b1, 1};
    vt[9] = '{32'h0000_1002, 32'h00000013, 1'b1, 1};

    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b0;
      prog_we[i] = 1'b0; prog_addr[i] = '0; prog_wdata[i] = '0;
    end
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d valid", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("reset%0d ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("reset%0d busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset%0d instr", i), resp_instr[i], 32'd0);
      chk($sformatf("reset%0d err", i), 32'(resp_err[i]), 32'd0);
      reset[i] = 1'b0;
    end

    for (int i = 0; i < 3; i++) preload(i);
    prog(0, 32'h0000_0FFC, 32'h12345678);

    for (int k = 0; k < 10; k++)
      fetch(0, vt[k].addr, vt[k].instr, vt[k].err, vt[k].lat, $sformatf("vec%0d", k));

    // Out-of-range write is dropped; low address bits are ignored on writes.
    prog(0, 32'h0000_1000, 32'hBAD0BAD0);
    fetch(0, 32'h0, 32'h00500093, 1'b0, 2, "oor_write");
    prog(0, 32'h0000_0FFE, 32'h0BADF00D);
    fetch(0, 32'h0000_0FFC, 32'h0BADF00D, 1'b0, 2, "lowbits_write");

    // Backpressure: response held 5 cycles, held request accepted only after release.
    resp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 32'h8;
    step();
    req_addr[0] = 32'h4;
    step();
    chk("bp valid", 32'(resp_valid[0]), 32'd1);
    held = resp_instr[0];
    chk("bp instr", held, 32'h002081B3);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp hold%0d valid", c), 32'(resp_valid[0]), 32'd1);
      chk($sformatf("bp hold%0d instr", c), resp_instr[0], held);
      chk($sformatf("bp hold%0d ready", c), 32'(req_ready[0]), 32'd0);
    end
    resp_ready[0] = 1'b1;
    step();
    chk("bp release valid", 32'(resp_valid[0]), 32'd0);
    chk("bp release ready", 32'(req_ready[0]), 32'd1);
    step();
    req_valid[0] = 1'b0;
    chk("bp accept busy", 32'(busy[0]), 32'd1);
    step();
    chk("bp second valid", 32'(resp_valid[0]), 32'd1);
    chk("bp second instr", resp_instr[0], 32'h00A00113);
    step();
    chk("bp second done", 32'(resp_valid[0]), 32'd0);

    // WAIT_CYCLES=3: reset in WAIT abandons the fetch.
    req_valid[1] = 1'b1; req_addr[1] = 32'h4; resp_ready[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    chk("rst accept busy", 32'(busy[1]), 32'd1);
    step();
    chk("rst in wait", 32'(resp_valid[1]), 32'd0);
    reset[1] = 1'b1;
    step();
    reset[1] = 1'b0;
    chk("rst valid", 32'(resp_valid[1]), 32'd0);
    chk("rst ready", 32'(req_ready[1]), 32'd1);
    chk("rst busy", 32'(busy[1]), 32'd0);
    step();
    chk("rst no late resp", 32'(resp_valid[1]), 32'd0);
    fetch(1, 32'h4, 32'h00A00113, 1'b0, 4, "wc3 after rst");
    fetch(1, 32'h7, 32'h00000013, 1'b1, 1, "wc3 err");

    // Write during WAIT to the in-flight word is visible in the response.
    req_valid[1] = 1'b1; req_addr[1] = 32'hC;
    step();
    req_valid[1] = 1'b0;
    prog(1, 32'hC, 32'hCAFEF00D);
    step(); step();
    chk("wait write valid", 32'(resp_valid[1]), 32'd1);
    chk("wait write instr", resp_instr[1], 32'hCAFEF00D);
    step();

    // WAIT_CYCLES=0: capture on the write edge returns the old word.
    fetch(2, 32'h0, 32'h00500093, 1'b0, 1, "wc0 plain");
    req_valid[2] = 1'b1; req_addr[2] = 32'h8; resp_ready[2] = 1'b1;
    prog_we[2] = 1'b1; prog_addr[2] = 32'h8; prog_wdata[2] = 32'hDEADBEEF;
    step();
    req_valid[2] = 1'b0; prog_we[2] = 1'b0;
    chk("rbw valid", 32'(resp_valid[2]), 32'd1);
    chk("rbw instr", resp_instr[2], 32'h002081B3);
    chk("rbw err", 32'(resp_err[2]), 32'd0);
    step();
    fetch(2, 32'h8, 32'hDEADBEEF, 1'b0, 1, "wc0 refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
